// File: rtl/load_scoreboard_r0_pkg.sv
// Shared defaults and helpers for the load scoreboard and its destination FIFO.
package load_scoreboard_r0_pkg;

    localparam int LSB_BIT_WIDTH       = 5;
    localparam int LSB_MAX_OUTSTANDING = 4;
    localparam int ZERO_REG            = 0;

    // Occupancy counters need one extra bit so a full FIFO is representable.
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ld_dest_fifo_r0.sv
// In-order FIFO of load destination registers; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module ld_dest_fifo_r0
    import load_scoreboard_r0_pkg::*;
#(
    parameter int DATA_W = LSB_BIT_WIDTH,
    parameter int DEPTH  = LSB_MAX_OUTSTANDING
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_i,
    input  logic [DATA_W-1:0]         din_i,
    input  logic                      pop_i,
    output logic [DATA_W-1:0]         head_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/load_scoreboard_r0.sv
// Load-use scoreboard: per-register pending bitmap plus in-order destination
// FIFO; stalls ID on RAW/WAW against in-flight loads or a full load queue.
module load_scoreboard_r0
    import load_scoreboard_r0_pkg::*;
#(
    parameter int BIT_WIDTH       = LSB_BIT_WIDTH,
    parameter int MAX_OUTSTANDING = LSB_MAX_OUTSTANDING
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [BIT_WIDTH-1:0]              ID_Rs,
    input  logic [BIT_WIDTH-1:0]              ID_Rt,
    input  logic [BIT_WIDTH-1:0]              ID_Rd,
    input  logic                              ID_Valid,
    input  logic                              ID_MemToReg,
    input  logic                              ID_RegWrite,
    input  logic                              MEM_DATA_VALID,
    output logic                              Stall,
    output logic [BIT_WIDTH-1:0]              WB_Rd,
    output logic [$clog2(MAX_OUTSTANDING):0]  Outstanding,
    output logic                              Full,
    output logic                              Err_Underflow
);

    localparam int                   NREG  = 1 << BIT_WIDTH;
    localparam int                   CNT_W = count_w(MAX_OUTSTANDING);
    localparam logic [BIT_WIDTH-1:0] R0    = BIT_WIDTH'(ZERO_REG);

    logic [NREG-1:0]      pending_q, pending_d;
    logic                 err_q;
    logic [BIT_WIDTH-1:0] head;
    logic [CNT_W-1:0]     count;
    logic                 ret, issue;
    logic                 hot_rs, hot_rt, hot_rd;

    // A register returning this cycle is forwarded, so it is not hot.
    function automatic logic is_hot(input logic [NREG-1:0]      pend,
                                     input logic [BIT_WIDTH-1:0] r,
                                     input logic                 mdv,
                                     input logic [BIT_WIDTH-1:0] hd);
        return pend[r] && !(mdv && (hd == r)) && (r != R0);
    endfunction

    assign ret    = MEM_DATA_VALID && (count != '0);
    assign Full   = (count == CNT_W'(MAX_OUTSTANDING));
    assign hot_rs = is_hot(pending_q, ID_Rs, MEM_DATA_VALID, head);
    assign hot_rt = is_hot(pending_q, ID_Rt, MEM_DATA_VALID, head);
    assign hot_rd = is_hot(pending_q, ID_Rd, MEM_DATA_VALID, head);

    assign Stall = ID_Valid && (hot_rs || hot_rt || (ID_RegWrite && hot_rd) ||
                                (ID_MemToReg && Full && !MEM_DATA_VALID));

    assign issue = ID_Valid && ID_MemToReg && ID_RegWrite && (ID_Rd != R0) && !Stall;

    // Set after clear: a load may reissue the very register that is returning.
    always_comb begin
        pending_d = pending_q;
        if (ret)   pending_d[head]  = 1'b0;
        if (issue) pending_d[ID_Rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (MEM_DATA_VALID && (count == '0)) err_q <= 1'b1;
        end
    end

    ld_dest_fifo_r0 #(
        .DATA_W (BIT_WIDTH),
        .DEPTH  (MAX_OUTSTANDING)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (issue),
        .din_i   (ID_Rd),
        .pop_i   (ret),
        .head_o  (head),
        .count_o (count)
    );

    assign WB_Rd         = ret ? head : R0;
    assign Outstanding   = count;
    assign Err_Underflow = err_q;

endmodule

// File: tb/tb_load_scoreboard_r0.sv
// Bench for load_scoreboard_r0: directed vector table, hand-written reset and
// underflow sequences, then random traffic against a queue-based model.
module tb_load_scoreboard_r0;

    localparam int BW   = 5;
    localparam int MAXO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BW-1:0] ID_Rs = '0, ID_Rt = '0, ID_Rd = '0;
    logic          ID_Valid = 1'b0, ID_MemToReg = 1'b0, ID_RegWrite = 1'b0;
    logic          MEM_DATA_VALID = 1'b0;
    logic          Stall;
    logic [BW-1:0] WB_Rd;
    logic [2:0]    Outstanding;
    logic          Full;
    logic          Err_Underflow;

    load_scoreboard_r0 #(.BIT_WIDTH(BW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_Rd          (ID_Rd),
        .ID_Valid       (ID_Valid),
        .ID_MemToReg    (ID_MemToReg),
        .ID_RegWrite    (ID_RegWrite),
        .MEM_DATA_VALID (MEM_DATA_VALID),
        .Stall          (Stall),
        .WB_Rd          (WB_Rd),
        .Outstanding    (Outstanding),
        .Full           (Full),
        .Err_Underflow  (Err_Underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v, mtr, rw;
        logic [BW-1:0] rs, rt, rd;
        logic          mdv;
        logic          stall;
        logic [BW-1:0] wb;
        logic [2:0]    out;
        logic          full;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    // Reference model: the list of in-flight load destinations, oldest first.
    int q[$];
    bit err_m;

    function automatic vec_t mk(input int v, mtr, rw, rs, rt, rd, mdv,
                                input int st, wb, out, full);
        vec_t x;
        x.v = 1'(v); x.mtr = 1'(mtr); x.rw = 1'(rw);
        x.rs = BW'(rs); x.rt = BW'(rt); x.rd = BW'(rd);
        x.mdv = 1'(mdv); x.stall = 1'(st); x.wb = BW'(wb);
        x.out = 3'(out); x.full = 1'(full);
        return x;
    endfunction

    function automatic bit m_hot(input int r, input bit mdv);
        if (r == 0) return 1'b0;
        if (mdv && q.size() > 0 && q[0] == r) return 1'b0;
        foreach (q[i]) if (q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stall(input vec_t x);
        return x.v && (m_hot(int'(x.rs), x.mdv) || m_hot(int'(x.rt), x.mdv) ||
                       (x.rw && m_hot(int'(x.rd), x.mdv)) ||
                       (x.mtr && q.size() == MAXO && !x.mdv));
    endfunction

    function automatic vec_t m_expect(input vec_t x);
        vec_t y = x;
        y.stall = m_stall(x);
        y.wb    = (x.mdv && q.size() > 0) ? BW'(q[0]) : '0;
        y.out   = 3'(q.size());
        y.full  = (q.size() == MAXO);
        return y;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        ID_Valid = x.v; ID_MemToReg = x.mtr; ID_RegWrite = x.rw;
        ID_Rs = x.rs; ID_Rt = x.rt; ID_Rd = x.rd; MEM_DATA_VALID = x.mdv;
    endtask

    task automatic step(input vec_t x, input bit e_err, input string tag);
        bit st, iss, mret;
        @(negedge clk);
        drive(x);
        #1;
        chk({tag, " Stall"}, int'(Stall), int'(x.stall));
        chk({tag, " WB_Rd"}, int'(WB_Rd), int'(x.wb));
        chk({tag, " Outstanding"}, int'(Outstanding), int'(x.out));
        chk({tag, " Full"}, int'(Full), int'(x.full));
        chk({tag, " Err_Underflow"}, int'(Err_Underflow), int'(e_err));
        st   = m_stall(x);
        mret = x.mdv && q.size() > 0;
        iss  = x.v && x.mtr && x.rw && x.rd != 0 && !st;
        @(posedge clk);
        if (x.mdv && q.size() == 0) err_m = 1'b1;
        if (mret) void'(q.pop_front());
        if (iss) q.push_back(int'(x.rd));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        drive(mk(1, 1, 1, 3, 4, 5, 0, 0, 0, 0, 0));
        #1;
        q.delete();
        err_m = 1'b0;
        chk({tag, " rst Stall"}, int'(Stall), 0);
        chk({tag, " rst WB_Rd"}, int'(WB_Rd), 0);
        chk({tag, " rst Outstanding"}, int'(Outstanding), 0);
        chk({tag, " rst Full"}, int'(Full), 0);
        chk({tag, " rst Err_Underflow"}, int'(Err_Underflow), 0);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t x;
        // Load-use on r5, released by its own return
        tbl.push_back(mk(1,1,1, 0,0,5, 0,  0,0,0,0));
        tbl.push_back(mk(1,0,1, 5,0,6, 0,  1,0,1,0));
        tbl.push_back(mk(1,0,1, 5,0,6, 0,  1,0,1,0));
        tbl.push_back(mk(1,0,1, 5,0,6, 1,  0,5,1,0));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,  0,0,0,0));
        // Fill r1..r4, fifth load stalls, retry with a return
        tbl.push_back(mk(1,1,1, 0,0,1, 0,  0,0,0,0));
        tbl.push_back(mk(1,1,1, 0,0,2, 0,  0,0,1,0));
        tbl.push_back(mk(1,1,1, 0,0,3, 0,  0,0,2,0));
        tbl.push_back(mk(1,1,1, 0,0,4, 0,  0,0,3,0));
        tbl.push_back(mk(1,1,1, 0,0,8, 0,  1,0,4,1));
        tbl.push_back(mk(1,1,1, 0,0,8, 1,  0,1,4,1));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,  0,2,4,1));
        // WAW guard on r7, Rt hazard, bubble never stalls
        tbl.push_back(mk(1,1,1, 0,0,7, 0,  0,0,3,0));
        tbl.push_back(mk(1,0,1, 0,0,7, 0,  1,0,4,1));
        tbl.push_back(mk(1,0,1, 0,0,0, 0,  0,0,4,1));
        tbl.push_back(mk(1,0,0, 0,0,7, 0,  0,0,4,1));
        tbl.push_back(mk(1,0,0, 0,3,0, 0,  1,0,4,1));
        tbl.push_back(mk(0,0,1, 3,3,3, 0,  0,0,4,1));
        // Drain in order
        tbl.push_back(mk(0,0,0, 0,0,0, 1,  0,3,4,1));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,  0,4,3,0));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,  0,8,2,0));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,  0,7,1,0));
        // Loads to r0 are not tracked
        tbl.push_back(mk(1,1,1, 0,0,0, 0,  0,0,0,0));
        tbl.push_back(mk(1,0,1, 0,0,0, 0,  0,0,0,0));

        q.delete();
        err_m = 1'b0;
        repeat (2) @(posedge clk);
        do_reset("init");

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], 1'b0, $sformatf("vec%0d", i));

        // Underflow is sticky until reset
        step(mk(0,0,0, 0,0,0, 1,  0,0,0,0), 1'b0, "uflow");
        for (int i = 0; i < 3; i++)
            step(mk(0,0,0, 0,0,0, 0,  0,0,0,0), 1'b1, $sformatf("uflow_hold%0d", i));
        do_reset("uflow");
        step(mk(0,0,0, 0,0,0, 0,  0,0,0,0), 1'b0, "uflow_post");

        // Reset with three loads in flight
        step(mk(1,1,1, 0,0,9,  0,  0,0,0,0), 1'b0, "mid_ld9");
        step(mk(1,1,1, 0,0,10, 0,  0,0,1,0), 1'b0, "mid_ld10");
        step(mk(1,1,1, 0,0,11, 0,  0,0,2,0), 1'b0, "mid_ld11");
        do_reset("mid");
        step(mk(1,0,1, 9,10,11, 0,  0,0,0,0), 1'b0, "mid_use");
        step(mk(0,0,0, 0,0,0,   1,  0,0,0,0), 1'b0, "mid_ret");
        step(mk(0,0,0, 0,0,0,   0,  0,0,0,0), 1'b1, "mid_err");
        do_reset("rand");

        // Random traffic against the model, with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset($sformatf("rnd%0d", i));
            end else begin
                x = mk(int'($urandom_range(0, 9) < 8), int'($urandom_range(0, 1)),
                       int'($urandom_range(0, 9) < 8), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 9) < 3), 0, 0, 0, 0);
                step(m_expect(x), err_m, $sformatf("rnd%0d", i));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
